// File: rtl/remote_comm.sv
// remote_comm: 8N1 UART link sending 16-bit commands as two bytes and receiving 8-bit responses.
module remote_comm #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  input  logic [15:0] cmd,
  input  logic        send_cmd,
  output logic        cmd_sent,
  output logic        resp_rdy,
  output logic [7:0]  resp
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
  typedef enum logic [1:0] {IDLE, HIGH_BYTE, LOW_BYTE} tx_state_t;
  typedef enum logic {RX_IDLE, RX_BUSY} rx_state_t;
  tx_state_t tx_state;
  rx_state_t rx_state;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic [3:0] tx_bit, rx_bit;
  logic [18:0] tx_shift;
  logic [2:0] rx_sync;
  logic [7:0] rx_data;
  logic accept, tx_last, rx_s, fall;
  assign accept = send_cmd && tx_state == IDLE;
  assign tx_last = tx_cnt == LAST;
  assign rx_s = rx_sync[1];
  assign fall = rx_sync[2] & ~rx_sync[1];
  // Remaining 19 bits of both frames after the first start bit, shifted out LSB first.
  always_ff @(posedge clk)
    if (rst_n) begin
      tx_state <= IDLE;
      TX <= 1'b1;
      cmd_sent <= 1'b0;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_shift <= '0;
    end else if (accept) begin
      tx_state <= HIGH_BYTE;
      TX <= 1'b0;
      cmd_sent <= 1'b0;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_shift <= {1'b1, cmd[7:0], 1'b0, 1'b1, cmd[15:8]};
    end else if (tx_state != IDLE) begin
      tx_cnt <= tx_last ? '0 : tx_cnt + 1'b1;
      if (tx_last) begin
        tx_bit <= tx_bit == 4'd9 ? 4'd0 : tx_bit + 1'b1;
        TX <= tx_state == LOW_BYTE && tx_bit == 4'd9 ? 1'b1 : tx_shift[0];
        tx_shift <= tx_shift >> 1;
        if (tx_bit == 4'd9) begin
          tx_state <= tx_state == HIGH_BYTE ? LOW_BYTE : IDLE;
          cmd_sent <= tx_state == LOW_BYTE;
        end
      end
    end
  // rx_sync[1:0] is the synchronizer; rx_sync[2] holds the previous synchronized value for edge detection.
  always_ff @(posedge clk)
    if (rst_n) begin
      rx_sync <= 3'b111;
      rx_state <= RX_IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_data <= '0;
      resp <= '0;
      resp_rdy <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[1:0], RX};
      if (accept) resp_rdy <= 1'b0;
      if (rx_state == RX_IDLE) begin
        if (fall) begin
          rx_state <= RX_BUSY;
          rx_cnt <= '0;
          rx_bit <= '0;
          resp_rdy <= 1'b0;
        end
      end else if (rx_bit == 4'd0) begin
        if (rx_cnt == HALF) begin
          rx_cnt <= '0;
          rx_state <= rx_s ? RX_IDLE : RX_BUSY;
          rx_bit <= rx_s ? 4'd0 : 4'd1;
        end else rx_cnt <= rx_cnt + 1'b1;
      end else if (rx_cnt == LAST) begin
        rx_cnt <= '0;
        rx_bit <= rx_bit + 1'b1;
        rx_data <= {rx_s, rx_data[7:1]};
        if (rx_bit == 4'd9) begin
          resp <= rx_data;
          resp_rdy <= 1'b1;
          rx_state <= RX_IDLE;
        end
      end else rx_cnt <= rx_cnt + 1'b1;
    end
endmodule

// File: tb/tb_remote_comm.sv
// tb_remote_comm: randomized bench comparing remote_comm against a timeline-based reference model.
module tb_remote_comm;
  localparam int B = 16;
  localparam int H = B / 2;
  logic clk = 1'b0, rst_n = 1'b1, RX = 1'b1, send_cmd = 1'b0;
  logic [15:0] cmd = '0;
  logic TX, cmd_sent, resp_rdy;
  logic [7:0] resp;
  int checks = 0, errors = 0;
  bit m_busy, m_sent, m_rbusy, m_rdy;
  bit m_bits [20];
  int m_t, m_rt;
  logic [7:0] m_data, m_resp;
  logic [2:0] m_hist;
  always #5 clk = ~clk;
  remote_comm #(.BAUD_DIV(B)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd),
    .send_cmd(send_cmd), .cmd_sent(cmd_sent), .resp_rdy(resp_rdy), .resp(resp)
  );
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  // Model: TX is a 20-bit timeline indexed by cycles since start; RX samples at fixed offsets from the detected edge.
  initial begin
    bit fall, acc, setr, clr;
    int k;
    forever begin
      @(posedge clk);
      if (rst_n) begin
        m_busy = 0; m_sent = 0; m_rbusy = 0; m_rdy = 0; m_resp = '0; m_hist = 3'b111;
      end else begin
        fall = m_hist[2] & ~m_hist[1];
        acc = !m_busy && send_cmd;
        setr = 0;
        clr = acc;
        if (m_busy) begin
          m_t++;
          if (m_t == 20 * B) begin m_busy = 0; m_sent = 1; end
        end else if (send_cmd) begin
          m_busy = 1; m_t = 0; m_sent = 0;
          for (int i = 0; i < 8; i++) begin
            m_bits[1 + i] = cmd[8 + i];
            m_bits[11 + i] = cmd[i];
          end
          m_bits[0] = 0; m_bits[9] = 1; m_bits[10] = 0; m_bits[19] = 1;
        end
        if (m_rbusy) begin
          m_rt++;
          if (m_rt == H) begin
            if (m_hist[1]) m_rbusy = 0;
          end else if (m_rt > H && (m_rt - H) % B == 0) begin
            k = (m_rt - H) / B;
            if (k <= 8) m_data[k - 1] = m_hist[1];
            else begin m_resp = m_data; setr = 1; m_rbusy = 0; end
          end
        end else if (fall) begin
          m_rbusy = 1; m_rt = 0; clr = 1;
        end
        if (clr) m_rdy = 0;
        if (setr) m_rdy = 1;
        m_hist = {m_hist[1:0], RX};
      end
      #1;
      check("tx", TX, m_busy ? m_bits[m_t / B] : 1'b1);
      check("cmd_sent", cmd_sent, m_sent);
      check("resp_rdy", resp_rdy, m_rdy);
      check("resp", resp, m_resp);
    end
  end
  task automatic send(input logic [15:0] c);
    cmd = c;
    send_cmd = 1'b1;
    @(negedge clk);
    send_cmd = 1'b0;
  endtask
  task automatic rx_frame(input logic [7:0] d);
    logic [9:0] fr;
    fr = {1'b1, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = fr[i];
      repeat (B) @(negedge clk);
    end
  endtask
  initial begin
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    send(16'h2000);
    repeat (20 * B + 10) @(negedge clk);
    rx_frame(8'hA5);
    repeat (B) @(negedge clk);
    rx_frame(8'h5A);
    repeat (B) @(negedge clk);
    send(16'h6022);
    repeat (3 * B) @(negedge clk);
    send(16'hFFFF);
    repeat (20 * B) @(negedge clk);
    RX = 1'b0;
    repeat (6) @(negedge clk);
    RX = 1'b1;
    repeat (2 * B) @(negedge clk);
    send(16'h6022);
    repeat (15 * B) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    send(16'hC35A);
    repeat (20 * B + 10) @(negedge clk);
    for (int n = 0; n < 20; n++) begin
      fork
        begin
          repeat ($urandom_range(0, 20)) @(negedge clk);
          send(16'($urandom));
        end
        begin
          repeat ($urandom_range(30, 250)) @(negedge clk);
          send(16'($urandom));
        end
        begin
          repeat ($urandom_range(0, 200)) @(negedge clk);
          rx_frame(8'($urandom));
          repeat (B) @(negedge clk);
        end
      join
      repeat (20 * B + 20) @(negedge clk);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
